antares_ex_muldiv_unit: RTL and testbench

// - EX-stage consumer of the ID->EX pipeline register for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO.
// - Multi-cycle ops raise ex_md_stall, which the hazard unit ORs into ex_stall; the ID->EX register

---
 rtl/antares_ex_muldiv_unit_pkg.sv | 31 +++
 rtl/antares_ex_muldiv_unit_divider_core.sv | 81 ++++++++
 rtl/antares_ex_muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_antares_ex_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/antares_ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM
// states, and a small sign-magnitude helper.
package antares_ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    MD_STATE_IDLE = 3'd0,
    MD_STATE_MUL  = 3'd1,
    MD_STATE_DIV  = 3'd2,
    MD_STATE_FIX  = 3'd3,
    MD_STATE_DONE = 3'd4
  } md_state_e;

  localparam int DIV_ITERS = 32;

  // Magnitude of a two's complement value when en is set, raw value otherwise.
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/antares_ex_muldiv_unit_divider_core.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// start loads the operands; 32 iterations follow. last is high during the
// cycle whose clock edge produces the final quotient bit. abort cancels.
module antares_divider_core
  import antares_ex_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  // 33-bit partial remainder: previous remainder shifted left with the next
  // dividend bit, then trial-subtracted; bit 32 of diff is the borrow.
  logic [32:0] shifted;
  logic [32:0] diff;

  // One restoring step per cycle while busy; start/abort take priority.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = 5'd0;
    end else if (start) begin
      rem_d  = 32'd0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = 5'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (diff[32]) begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end else begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end
      cnt_d  = cnt_q + 5'd1;
      busy_d = (cnt_q != 5'(DIV_ITERS - 1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign last      = busy_q && (cnt_q == 5'(DIV_ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/antares_ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Handshake: while ex_md_stall is high the unit is busy and the hazard unit
// holds the ID->EX register (ex_stall high), keeping op and operands stable.
// When the result is committed the unit sits in DONE with ex_md_stall low and
// returns to IDLE on the first cycle ex_stall is low, i.e. when the
// instruction advances. ex_md_stall never depends on ex_stall.
module antares_ex_muldiv_unit
  import antares_ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_md_op,
  input  logic [31:0] ex_data_rs,
  input  logic [31:0] ex_data_rt,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        ex_md_stall,
  output logic [31:0] ex_hi,
  output logic [31:0] ex_lo,
  output md_state_e   ex_md_state
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;

  logic        mul_start;
  logic        div_start;
  logic        div_signed;
  logic        mul_ext;
  logic [63:0] mul_prod;

  logic [MUL_CYCLES-1:0] mul_vld_q, mul_vld_d;
  logic [63:0]           mul_prod_q [MUL_CYCLES];
  logic [63:0]           mul_prod_d [MUL_CYCLES];

  logic        div_last;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned multiply equal to the signed product for MULT.
  assign mul_ext    = (ex_md_op == MD_MULT);
  assign div_signed = (ex_md_op == MD_DIV);
  assign mul_prod   = {{32{mul_ext & ex_data_rs[31]}}, ex_data_rs} *
                      {{32{mul_ext & ex_data_rt[31]}}, ex_data_rt};

  antares_divider_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (ex_flush),
    .dividend  (abs32(ex_data_rs, div_signed)),
    .divisor   (abs32(ex_data_rt, div_signed)),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Product pipeline: stage 0 captures the product at the start edge; the
  // tail valid bit marks the last MUL cycle. Flush empties it.
  always_comb begin
    mul_vld_d[0]  = mul_start;
    mul_prod_d[0] = mul_prod;
    for (int i = 1; i < MUL_CYCLES; i++) begin
      mul_vld_d[i]  = mul_vld_q[i-1];
      mul_prod_d[i] = mul_prod_q[i-1];
    end
    if (ex_flush) mul_vld_d = '0;
  end

  // Product pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld_q <= '0;
      for (int i = 0; i < MUL_CYCLES; i++) mul_prod_q[i] <= '0;
    end else begin
      mul_vld_q <= mul_vld_d;
      for (int i = 0; i < MUL_CYCLES; i++) mul_prod_q[i] <= mul_prod_d[i];
    end
  end

  // Next-state, HI/LO updates and stall; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    mul_start   = 1'b0;
    div_start   = 1'b0;
    ex_md_stall = 1'b0;
    case (state_q)
      MD_STATE_IDLE: begin
        if (!ex_flush) begin
          case (ex_md_op)
            MD_MULT, MD_MULTU: begin
              mul_start   = 1'b1;
              ex_md_stall = 1'b1;
              state_d     = MD_STATE_MUL;
            end
            MD_DIV, MD_DIVU: begin
              div_start   = 1'b1;
              ex_md_stall = 1'b1;
              neg_quo_d   = div_signed & (ex_data_rs[31] ^ ex_data_rt[31]);
              neg_rem_d   = div_signed & ex_data_rs[31];
              div_zero_d  = (ex_data_rt == 32'd0);
              state_d     = MD_STATE_DIV;
            end
            MD_MTHI: hi_d = ex_data_rs;
            MD_MTLO: lo_d = ex_data_rs;
            default: ;
          endcase
        end
      end
      MD_STATE_MUL: begin
        ex_md_stall = 1'b1;
        if (mul_vld_q[MUL_CYCLES-1]) begin
          {hi_d, lo_d} = mul_prod_q[MUL_CYCLES-1];
          state_d      = MD_STATE_DONE;
        end
      end
      MD_STATE_DIV: begin
        ex_md_stall = 1'b1;
        if (div_last) state_d = MD_STATE_FIX;
      end
      MD_STATE_FIX: begin
        ex_md_stall = 1'b1;
        // Divide by zero reports all-ones quotient; remainder already equals rs.
        lo_d    = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (32'd0 - div_quo) : div_quo);
        hi_d    = neg_rem_q ? (32'd0 - div_rem) : div_rem;
        state_d = MD_STATE_DONE;
      end
      MD_STATE_DONE: begin
        if (!ex_stall) state_d = MD_STATE_IDLE;
      end
      default: state_d = MD_STATE_IDLE;
    endcase
    if (ex_flush) begin
      state_d = MD_STATE_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // FSM state, HI/LO and latched divide sign flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_STATE_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign ex_hi       = hi_q;
  assign ex_lo       = lo_q;
  assign ex_md_state = state_q;

endmodule

// File: tb/tb_antares_ex_muldiv_unit.sv
// Directed bench for antares_ex_muldiv_unit. The hazard unit is modelled as
// ex_stall = ex_md_stall | ext_stall; the ID->EX register is modelled by
// holding op/operands until an edge where ex_stall is low.
module tb_antares_ex_muldiv_unit;
  import antares_ex_muldiv_unit_pkg::*;

  localparam int MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_data_rs;
  logic [31:0] ex_data_rt;
  logic        ex_stall;
  logic        ext_stall;
  logic        ex_flush;
  logic        ex_md_stall;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  md_state_e   ex_md_state;

  int checks   = 0;
  int failures = 0;

  assign ex_stall = ex_md_stall | ext_stall;

  antares_ex_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_md_op    (ex_md_op),
    .ex_data_rs  (ex_data_rs),
    .ex_data_rt  (ex_data_rt),
    .ex_stall    (ex_stall),
    .ex_flush    (ex_flush),
    .ex_md_stall (ex_md_stall),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_md_state (ex_md_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Present an instruction, hold it until it advances, count md stall cycles.
  // Called and returns 1 time unit after a rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int md_cycles);
    bit advanced;
    advanced   = 1'b0;
    md_cycles  = 0;
    ex_md_op   = op;
    ex_data_rs = a;
    ex_data_rt = b;
    for (int i = 0; i < 100 && !advanced; i++) begin
      @(negedge clk);
      if (ex_md_stall) md_cycles++;
      if (!ex_stall) advanced = 1'b1;
    end
    checks++;
    if (!advanced) begin
      failures++;
      $display("FAIL run_op_timeout op=%0d stall_cycles=%0d required advance within 100", op, md_cycles);
    end
    @(posedge clk); #1;
    ex_md_op   = MD_NONE;
    ex_data_rs = 32'd0;
    ex_data_rt = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_stall = 1'b0; ex_flush = 1'b0;
    ex_md_op = MD_NONE; ex_data_rs = 32'd0; ex_data_rt = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ex_hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", ex_hi); end
    checks++; if (ex_lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", ex_lo); end
    checks++; if (ex_md_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ex_md_stall); end
    checks++; if (ex_md_state !== MD_STATE_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", ex_md_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int n;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n != 1 + MUL_CYCLES) begin failures++; $display("FAIL mult_stall got=%0d exp=%0d", n, 1 + MUL_CYCLES); end
    checks++; if (ex_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", ex_hi); end
    checks++; if (ex_lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", ex_lo); end
    checks++; if (ex_md_state !== MD_STATE_IDLE) begin failures++; $display("FAIL mult_state got=%0d exp=IDLE", ex_md_state); end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++; if (n != 1 + MUL_CYCLES) begin failures++; $display("FAIL multu_stall got=%0d exp=%0d", n, 1 + MUL_CYCLES); end
    checks++; if (ex_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", ex_hi); end
    checks++; if (ex_lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", ex_lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n != 34) begin failures++; $display("FAIL div_stall got=%0d exp=34", n); end
    checks++; if (ex_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", ex_lo); end
    checks++; if (ex_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", ex_hi); end
    run_op(MD_DIVU, 32'd100, 32'd0, n);
    checks++; if (n != 34) begin failures++; $display("FAIL divu0_stall got=%0d exp=34", n); end
    checks++; if (ex_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", ex_lo); end
    checks++; if (ex_hi !== 32'd100) begin failures++; $display("FAIL divu0_hi got=%h exp=00000064", ex_hi); end
  endtask

  task automatic test_div_boundary();
    int n;
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (ex_lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", ex_lo); end
    checks++; if (ex_hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", ex_hi); end
    run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, n);
    checks++; if (n != 34) begin failures++; $display("FAIL div0_stall got=%0d exp=34", n); end
    checks++; if (ex_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", ex_lo); end
    checks++; if (ex_hi !== 32'hFFFF_FFFB) begin failures++; $display("FAIL div0_hi got=%h exp=fffffffb", ex_hi); end
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, n);
    checks++; if (ex_lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negdvs_lo got=%h exp=fffffffd", ex_lo); end
    checks++; if (ex_hi !== 32'd1) begin failures++; $display("FAIL div_negdvs_hi got=%h exp=00000001", ex_hi); end
    run_op(MD_DIVU, 32'd1000, 32'd7, n);
    checks++; if (ex_lo !== 32'd142) begin failures++; $display("FAIL divu_lo got=%h exp=0000008e", ex_lo); end
    checks++; if (ex_hi !== 32'd6) begin failures++; $display("FAIL divu_hi got=%h exp=00000006", ex_hi); end
  endtask

  task automatic test_flush();
    int n;
    run_op(MD_MTHI, 32'hCAFE_0001, 32'd0, n);
    run_op(MD_MTLO, 32'hBEEF_0002, 32'd0, n);
    checks++; if (ex_hi !== 32'hCAFE_0001) begin failures++; $display("FAIL mthi_hi got=%h exp=cafe0001", ex_hi); end
    checks++; if (ex_lo !== 32'hBEEF_0002) begin failures++; $display("FAIL mtlo_lo got=%h exp=beef0002", ex_lo); end
    ex_md_op = MD_DIV; ex_data_rs = 32'd1000; ex_data_rt = 32'd3;
    @(negedge clk);
    checks++; if (ex_md_stall !== 1'b1) begin failures++; $display("FAIL flush_start_stall got=%b exp=1", ex_md_stall); end
    repeat (11) @(posedge clk);
    #1 ex_flush = 1'b1;
    @(negedge clk);
    checks++; if (ex_md_state !== MD_STATE_DIV) begin failures++; $display("FAIL flush_pre_state got=%0d exp=DIV", ex_md_state); end
    checks++; if (ex_md_stall !== 1'b1) begin failures++; $display("FAIL flush_cycle_stall got=%b exp=1", ex_md_stall); end
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_md_op = MD_NONE; ex_data_rs = 32'd0; ex_data_rt = 32'd0;
    @(negedge clk);
    checks++; if (ex_md_state !== MD_STATE_IDLE) begin failures++; $display("FAIL flush_state got=%0d exp=IDLE", ex_md_state); end
    checks++; if (ex_md_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", ex_md_stall); end
    checks++; if (ex_hi !== 32'hCAFE_0001) begin failures++; $display("FAIL flush_hi got=%h exp=cafe0001", ex_hi); end
    checks++; if (ex_lo !== 32'hBEEF_0002) begin failures++; $display("FAIL flush_lo got=%h exp=beef0002", ex_lo); end
    repeat (40) @(negedge clk);
    checks++; if (ex_hi !== 32'hCAFE_0001) begin failures++; $display("FAIL flush_late_hi got=%h exp=cafe0001", ex_hi); end
    checks++; if (ex_lo !== 32'hBEEF_0002) begin failures++; $display("FAIL flush_late_lo got=%h exp=beef0002", ex_lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    ex_md_op = MD_MULT; ex_data_rs = 32'd3; ex_data_rt = 32'd4;
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (ex_md_state !== MD_STATE_MUL) begin failures++; $display("FAIL rstmul_pre_state got=%0d exp=MUL", ex_md_state); end
    rst = 1'b1; ex_md_op = MD_NONE; ex_data_rs = 32'd0; ex_data_rt = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ex_hi !== 32'd0) begin failures++; $display("FAIL rstmul_hi got=%h exp=0", ex_hi); end
    checks++; if (ex_lo !== 32'd0) begin failures++; $display("FAIL rstmul_lo got=%h exp=0", ex_lo); end
    checks++; if (ex_md_state !== MD_STATE_IDLE) begin failures++; $display("FAIL rstmul_state got=%0d exp=IDLE", ex_md_state); end
    checks++; if (ex_md_stall !== 1'b0) begin failures++; $display("FAIL rstmul_stall got=%b exp=0", ex_md_stall); end
    repeat (MUL_CYCLES + 2) @(negedge clk);
    checks++; if (ex_lo !== 32'd0) begin failures++; $display("FAIL rstmul_late_lo got=%h exp=0", ex_lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    bit dropped;
    n = 0; dropped = 1'b0;
    ext_stall = 1'b1;
    ex_md_op = MD_MULT; ex_data_rs = 32'h0001_0000; ex_data_rt = 32'h0003_0000;
    for (int i = 0; i < 50 && !dropped; i++) begin
      @(negedge clk);
      if (ex_md_stall) n++;
      else dropped = 1'b1;
    end
    checks++; if (!dropped || n != 1 + MUL_CYCLES) begin failures++; $display("FAIL extstall_mul_stall got=%0d exp=%0d", n, 1 + MUL_CYCLES); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (ex_md_state !== MD_STATE_DONE) begin failures++; $display("FAIL extstall_state[%0d] got=%0d exp=DONE", k, ex_md_state); end
      checks++; if (ex_md_stall !== 1'b0) begin failures++; $display("FAIL extstall_stall[%0d] got=%b exp=0", k, ex_md_stall); end
      checks++; if (ex_hi !== 32'd3) begin failures++; $display("FAIL extstall_hi[%0d] got=%h exp=00000003", k, ex_hi); end
      checks++; if (ex_lo !== 32'd0) begin failures++; $display("FAIL extstall_lo[%0d] got=%h exp=0", k, ex_lo); end
    end
    ext_stall = 1'b0;
    @(posedge clk); #1;
    ex_md_op = MD_NONE; ex_data_rs = 32'd0; ex_data_rt = 32'd0;
    @(negedge clk);
    checks++; if (ex_md_state !== MD_STATE_IDLE) begin failures++; $display("FAIL extstall_release_state got=%0d exp=IDLE", ex_md_state); end
    @(posedge clk); #1;
    run_op(MD_MTLO, 32'h1234_5678, 32'd0, n);
    checks++; if (n != 0) begin failures++; $display("FAIL mtlo_stall got=%0d exp=0", n); end
    checks++; if (ex_lo !== 32'h1234_5678) begin failures++; $display("FAIL mtlo2_lo got=%h exp=12345678", ex_lo); end
    checks++; if (ex_hi !== 32'd3) begin failures++; $display("FAIL mtlo2_hi got=%h exp=00000003", ex_hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_boundary();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
